instr_encode_loader: RTL and testbench

- Inverse of the single-cycle control decode path: takes compact instruction records (operation select plus fields), encodes each into a 32-bit MIPS word, and streams the words into instruction memory.
- Used by the test/bring-up harness to load programs for the single-cycle CPU.
- Records enter through a valid/ready handshake into a small FIFO.
- The FIFO drains through an instruction-memory write port driven by an auto-incrementing byte-address counter.

---
 rtl/instr_encode_loader_if.sv | 36 +++
 rtl/instr_encode_loader.sv | 126 ++++++++++++
 tb/tb_instr_encode_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// Record-in / instruction-memory-out bundle for the program loader.
// master = harness side, slave = loader side.
interface instr_encode_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              im_stall;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [15:0]       word_cnt;
  logic [7:0]        err_cnt;
  logic              done;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, in_last, im_stall,
    input  in_ready, im_we, im_addr, im_wdata, word_cnt, err_cnt, done
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, in_last, im_stall,
    output in_ready, im_we, im_addr, im_wdata, word_cnt, err_cnt, done
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes compact instruction records into MIPS words, queues them in a FIFO
// and streams them into instruction memory at auto-incrementing byte addresses.
module instr_encode_loader #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_encode_loader_if.slave  bus
);
  // Handshake: a record transfers on a rising edge where in_valid & in_ready.
  // in_ready depends only on registered state (no same-cycle bypass).

  localparam int             PW   = $clog2(DEPTH);
  localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_RTYPE = 3'd0,
    OP_LW    = 3'd1,
    OP_SW    = 3'd2,
    OP_BEQ   = 3'd3,
    OP_J     = 3'd4,
    OP_ADDIU = 3'd5,
    OP_BGTZ  = 3'd6,
    OP_NOP   = 3'd7
  } op_e;

  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] addr;
  logic              last_seen;

  logic [31:0]       enc_word;
  logic              enc_bad;
  logic              accept;
  logic              push;
  logic              pop;

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (op_e'(bus.in_op))
      OP_RTYPE: begin
        enc_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
        case (bus.in_funct)
          6'd0, 6'd2, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42: enc_bad = 1'b0;
          default: enc_bad = 1'b1;
        endcase
      end
      OP_LW:    enc_word = {6'd35, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_SW:    enc_word = {6'd43, bus.in_rs, bus.in_rt, bus.in_imm};
      OP_BEQ:   enc_word = {6'd4,  bus.in_rs, bus.in_rt, bus.in_imm};
      OP_J:     enc_word = {6'd2,  bus.in_target};
      OP_ADDIU: enc_word = {6'd9,  bus.in_rs, bus.in_rt, bus.in_imm};
      // BGTZ has no rt operand; the field is architecturally zero.
      OP_BGTZ:  enc_word = {6'd7,  bus.in_rs, 5'd0, bus.in_imm};
      OP_NOP:   enc_word = 32'd0;
      default:  enc_word = 32'd0;
    endcase
  end

  assign bus.in_ready = (count < FULL) & ~last_seen;
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = accept & ~enc_bad;
  assign pop          = (count != '0) & ~bus.im_stall;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      addr         <= BASE_ADDR;
      last_seen    <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= BASE_ADDR;
      bus.im_wdata <= 32'd0;
      bus.word_cnt <= 16'd0;
      bus.err_cnt  <= 8'd0;
      bus.done     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.im_we    <= 1'b1;
        bus.im_addr  <= addr;
        bus.im_wdata <= mem[rd_ptr];
        addr         <= addr + ADDR_W'(4);
        bus.word_cnt <= bus.word_cnt + 16'd1;
      end else begin
        bus.im_we <= 1'b0;
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      if (accept && enc_bad && bus.err_cnt != 8'hFF) begin
        bus.err_cnt <= bus.err_cnt + 8'd1;
      end

      if (accept && bus.in_last) begin
        last_seen <= 1'b1;
      end

      // Once the last record is in and the FIFO has emptied, the final word
      // (if any) is being written this cycle, so done rises on the next edge.
      if (last_seen && count == '0) begin
        bus.done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: two instances (32-bit and 4-bit
// address) share stimulus; a negedge monitor checks writes against queues.
module tb_instr_encode_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        im_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;
  logic done_q = 1'b0;

  logic [63:0] exp1_q[$];
  logic [63:0] exp2_q[$];
  int          wr_cyc[$];
  logic [31:0] exp_a1;
  logic [3:0]  exp_a2;

  instr_encode_loader_if #(.ADDR_W(32)) b1 ();
  instr_encode_loader_if #(.ADDR_W(4))  b2 ();

  instr_encode_loader #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  instr_encode_loader #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'hC)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave));

  assign b1.in_valid = in_valid;   assign b2.in_valid = in_valid;
  assign b1.in_op = in_op;         assign b2.in_op = in_op;
  assign b1.in_rs = in_rs;         assign b2.in_rs = in_rs;
  assign b1.in_rt = in_rt;         assign b2.in_rt = in_rt;
  assign b1.in_rd = in_rd;         assign b2.in_rd = in_rd;
  assign b1.in_shamt = in_shamt;   assign b2.in_shamt = in_shamt;
  assign b1.in_funct = in_funct;   assign b2.in_funct = in_funct;
  assign b1.in_imm = in_imm;       assign b2.in_imm = in_imm;
  assign b1.in_target = in_target; assign b2.in_target = in_target;
  assign b1.in_last = in_last;     assign b2.in_last = in_last;
  assign b1.im_stall = im_stall;   assign b2.im_stall = im_stall;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (b1.done && !done_q) done_cyc = cyc;
    done_q = b1.done;
    if (b1.im_we) begin
      n_checks++;
      assert (exp1_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr1_extra: observed write %0h@%0h expected none", b1.im_wdata, b1.im_addr);
      end
      if (exp1_q.size() != 0) check("wr1", {b1.im_addr, b1.im_wdata}, exp1_q.pop_front());
      wr_cyc.push_back(cyc);
    end
    if (b2.im_we) begin
      n_checks++;
      assert (exp2_q.size() != 0) else begin
        n_fail++;
        $error("FAIL wr2_extra: observed write %0h@%0h expected none", b2.im_wdata, b2.im_addr);
      end
      if (exp2_q.size() != 0) check("wr2", {28'd0, b2.im_addr, b2.im_wdata}, exp2_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                      input logic [15:0] imm, input logic [25:0] target, input logic last,
                      input logic [31:0] exp_word, input logic keep);
    if (keep) begin
      exp1_q.push_back({exp_a1, exp_word});
      exp2_q.push_back({28'd0, exp_a2, exp_word});
      exp_a1 = exp_a1 + 32'd4;
      exp_a2 = exp_a2 + 4'd4;
    end
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
    in_funct = funct; in_imm = imm; in_target = target; in_last = last;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !b1.in_ready; k++) tick(1);
    if (!b1.in_ready) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
    end else begin
      tick(1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && (exp1_q.size() != 0 || exp2_q.size() != 0); k++) tick(1);
    n_checks++;
    assert (exp1_q.size() == 0 && exp2_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d/%0d pending expected 0", exp1_q.size(), exp2_q.size());
    end
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp1_q.delete();
    exp2_q.delete();
    wr_cyc.delete();
    exp_a1 = 32'h0;
    exp_a2 = 4'hC;
    done_cyc = 0;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    im_stall = 1'b0; exp_a1 = 32'h0; exp_a2 = 4'hC;
    tick(2);
    check("rst_we",       b1.im_we, 0);
    check("rst_addr",     b1.im_addr, 0);
    check("rst_addr2",    b2.im_addr, 4'hC);
    check("rst_wdata",    b1.im_wdata, 0);
    check("rst_word_cnt", b1.word_cnt, 0);
    check("rst_err_cnt",  b1.err_cnt, 0);
    check("rst_done",     b1.done, 0);
    check("rst_ready",    b1.in_ready, 1);
    rst = 1'b0;
    tick(1);

    // LW then ADDIU(last); dut2 wraps 0xC -> 0x0.
    send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 32'h8FA80004, 1'b1);
    send(3'd5, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 32'h2509FFFF, 1'b1);
    wait_drain();
    check("t1_word_cnt", b1.word_cnt, 2);
    check("t1_done",     b1.done, 1);
    check("t1_nwrites",  wr_cyc.size(), 2);
    check("t1_done_lat", done_cyc, wr_cyc[1] + 1);
    check("t1_ready",    b1.in_ready, 0);

    // RTYPE add, J, BGTZ with nonzero rt that must be dropped.
    do_reset();
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32, 16'h0, 26'd0, 1'b0, 32'h00221820, 1'b1);
    send(3'd4, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 5'd0, 6'd0,
         16'h0, 26'h100, 1'b0, 32'h08000100, 1'b1);
    send(3'd6, 5'd5, 5'd7, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1, 32'h1CA0FFFE, 1'b1);
    wait_drain();
    check("t2_word_cnt", b1.word_cnt, 3);
    check("t2_done",     b1.done, 1);

    // Six records into a stalled memory; FIFO fills at four.
    do_reset();
    im_stall = 1'b1;
    send(3'd7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)),
         26'($urandom_range(0, 1000)), 1'b0, 32'h00000000, 1'b1);
    send(3'd2, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 32'hAC430010, 1'b1);
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b0, 32'h10220003, 1'b1);
    send(3'd0, 5'd0, 5'd4, 5'd5, 5'd2, 6'd0, 16'h0, 26'd0, 1'b0, 32'h00042880, 1'b1);
    check("t3_full_ready", b1.in_ready, 0);
    tick(3);
    check("t3_stall_we",  b1.im_we, 0);
    check("t3_stall_cnt", b1.word_cnt, 0);
    fork
      begin
        tick(1);
        im_stall = 1'b0;
      end
    join_none
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd42, 16'h0, 26'd0, 1'b0, 32'h0022182A, 1'b1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF, 1'b1);
    wait_drain();
    check("t3_nwrites",  wr_cyc.size(), 6);
    check("t3_no_gaps",  wr_cyc[5] - wr_cyc[0], 5);
    check("t3_word_cnt", b1.word_cnt, 6);

    // Rejected RTYPE between valid records; final record rejected but last.
    do_reset();
    send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b0, 32'h8C018000, 1'b1);
    send(3'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'd8, 16'h0, 26'd0, 1'b0, 32'h0, 1'b0);
    send(3'd5, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0, 32'h24010001, 1'b1);
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd1, 16'h0, 26'd0, 1'b1, 32'h0, 1'b0);
    wait_drain();
    check("t4_err_cnt",  b1.err_cnt, 2);
    check("t4_word_cnt", b1.word_cnt, 2);
    check("t4_done",     b1.done, 1);
    check("t4_ready",    b1.in_ready, 0);

    // Reset with three words queued behind a stall.
    do_reset();
    im_stall = 1'b1;
    send(3'd5, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0011, 26'd0, 1'b0, 32'h24210011, 1'b1);
    send(3'd5, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0022, 26'd0, 1'b0, 32'h24210022, 1'b1);
    send(3'd5, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0033, 26'd0, 1'b0, 32'h24210033, 1'b1);
    check("t5_queued_cnt", b1.word_cnt, 0);
    im_stall = 1'b0;
    do_reset();
    check("t5_we",       b1.im_we, 0);
    check("t5_word_cnt", b1.word_cnt, 0);
    check("t5_ready",    b1.in_ready, 1);
    check("t5_done",     b1.done, 0);
    check("t5_err_cnt",  b1.err_cnt, 0);
    tick(2);
    check("t5_no_stale", b1.word_cnt, 0);
    send(3'd5, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 32'h24431234, 1'b1);
    wait_drain();
    check("t5_after_cnt", b1.word_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
